// File: rtl/mux_alu_pkg.sv
// ---------------------------------------------------------------------------
// mux_alu_pkg
// Shared types for the two-operand channel-mux ALU pipeline:
//   op_e        - 3-bit ALU opcode
//   alu_flags_t - result flags registered alongside out_data
//   OPC_*       - plain opcode constants for code that drives raw 3-bit ops
// Optional build macro used by the design: MUX_ALU_SAT_EN (see mux_alu_core).
// ---------------------------------------------------------------------------
package mux_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_PASS = 3'b101,
    OP_SHL  = 3'b110,
    OP_SHR  = 3'b111
  } op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
    logic err;
  } alu_flags_t;

  localparam logic [2:0] OPC_ADD  = 3'b000;
  localparam logic [2:0] OPC_SUB  = 3'b001;
  localparam logic [2:0] OPC_AND  = 3'b010;
  localparam logic [2:0] OPC_OR   = 3'b011;
  localparam logic [2:0] OPC_XOR  = 3'b100;
  localparam logic [2:0] OPC_PASS = 3'b101;
  localparam logic [2:0] OPC_SHL  = 3'b110;
  localparam logic [2:0] OPC_SHR  = 3'b111;

endpackage

// File: rtl/mux_alu_core.sv
// ---------------------------------------------------------------------------
// mux_alu_core
// Purely combinational 8-op ALU.
// Ports:
//   a_i, b_i   [WIDTH-1:0]  operands
//   op_i       op_e         opcode
//   result_o   [WIDTH-1:0]  result (saturated when MUX_ALU_SAT_EN is defined)
//   carry_o                 ADD carry-out / SUB borrow / last bit shifted out
//   ovf_o                   signed overflow for ADD/SUB, 0 otherwise
// Build macro: MUX_ALU_SAT_EN - ADD clamps to all-ones on carry, SUB clamps
// to zero on borrow. carry_o/ovf_o always report the unsaturated event.
// ---------------------------------------------------------------------------
module mux_alu_core
  import mux_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH-1:0]   raw;

  assign shamt = b_i[SHAMT_W-1:0];
  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  // Top bit of the extended difference is the borrow, i.e. (a < b).
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  // One guard bit on the shifted-out side captures the last bit lost;
  // a zero shift leaves the guard bit clear.
  assign shl_ext = {1'b0, a_i} << shamt;
  assign shr_ext = {a_i, 1'b0} >> shamt;

  always_comb begin
    raw     = '0;
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    case (op_i)
      OP_ADD: begin
        raw     = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
        ovf_o   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (raw[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        raw     = diff[WIDTH-1:0];
        carry_o = diff[WIDTH];
        ovf_o   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (raw[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  raw = a_i & b_i;
      OP_OR:   raw = a_i | b_i;
      OP_XOR:  raw = a_i ^ b_i;
      OP_PASS: raw = a_i;
      OP_SHL: begin
        raw     = shl_ext[WIDTH-1:0];
        carry_o = shl_ext[WIDTH];
      end
      OP_SHR: begin
        raw     = shr_ext[WIDTH:1];
        carry_o = shr_ext[0];
      end
      default: raw = '0;
    endcase
  end

`ifdef MUX_ALU_SAT_EN
  always_comb begin
    result_o = raw;
    if (op_i == OP_ADD && carry_o) begin
      result_o = '1;
    end else if (op_i == OP_SUB && carry_o) begin
      result_o = '0;
    end
  end
`else
  assign result_o = raw;
`endif

endmodule

// File: rtl/mux_alu_pipe.sv
// ---------------------------------------------------------------------------
// mux_alu_pipe
// Two-stage valid/ready pipeline: NUM_CH channel mux -> two operand selects
// -> 8-op ALU (mux_alu_core) -> registered result and flags.
//   S1: captures operand A/B, opcode and select-range error on accept.
//   S2: captures ALU result and flags; out_valid is S2's valid bit.
// Ports:
//   clk, rstn                    clock (rising), async active-low reset
//   in_valid / in_ready          input handshake
//   ch_data [NUM_CH*WIDTH-1:0]   flattened channels, ch k at [k*WIDTH +: WIDTH]
//   sel_a, sel_b [SEL_W-1:0]     operand channel selects
//   op [2:0]                     opcode (mux_alu_pkg::op_e)
//   out_valid / out_ready        output handshake
//   out_data [WIDTH-1:0]         result
//   carry, zero, ovf, err        result flags
// Build macro: MUX_ALU_SAT_EN (saturating ADD/SUB inside mux_alu_core).
// ---------------------------------------------------------------------------
module mux_alu_pipe
  import mux_alu_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  input  logic [SEL_W-1:0]        sel_a,
  input  logic [SEL_W-1:0]        sel_b,
  input  logic [2:0]              op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    carry,
  output logic                    zero,
  output logic                    ovf,
  output logic                    err
);

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  op_e              s1_op_q;
  logic             s1_err_q;

  // Stage 2 registers
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_data_q;
  alu_flags_t       flags_q, flags_d;

  logic             accept;
  logic             s2_load;
  logic [WIDTH-1:0] opa_mux;
  logic [WIDTH-1:0] opb_mux;
  logic             sel_err;
  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic             core_ovf;

  // Channel mux. NUM_CH need not be a power of two, so unmatched select
  // codes fall through to a zero operand and raise err.
  always_comb begin
    opa_mux = '0;
    opb_mux = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(sel_a) == k) opa_mux = ch_data[k*WIDTH +: WIDTH];
      if (int'(sel_b) == k) opb_mux = ch_data[k*WIDTH +: WIDTH];
    end
  end

  assign sel_err = (int'(sel_a) >= NUM_CH) || (int'(sel_b) >= NUM_CH);

  // in_ready depends only on registers and out_ready, never on in_valid.
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  mux_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .op_i     (s1_op_q),
    .result_o (core_res),
    .carry_o  (core_carry),
    .ovf_o    (core_ovf)
  );

  // zero is taken from the core's final (possibly saturated) result.
  always_comb begin
    flags_d       = '0;
    flags_d.carry = core_carry;
    flags_d.zero  = (core_res == '0);
    flags_d.ovf   = core_ovf;
    flags_d.err   = s1_err_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_ADD;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        s1_a_q   <= opa_mux;
        s1_b_q   <= opb_mux;
        s1_op_q  <= op_e'(op);
        s1_err_q <= sel_err;
      end
      if (s2_load) begin
        out_data_q <= core_res;
        flags_q    <= flags_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign ovf       = flags_q.ovf;
  assign err       = flags_q.err;

endmodule

// File: tb/tb_mux_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_mux_alu_pipe
// Directed bench for mux_alu_pipe: one 4-channel instance for the main
// sequence and a 5-channel instance for out-of-range select handling.
// Expected ADD/SUB results follow MUX_ALU_SAT_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_mux_alu_pipe;
  import mux_alu_pkg::*;

`ifdef MUX_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        rstn;

  // 4-channel instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] ch_data;
  logic [1:0]  sel_a, sel_b;
  logic [2:0]  op;
  logic [7:0]  out_data;
  logic        carry, zero, ovf, err;

  // 5-channel instance
  logic        in_valid5, in_ready5, out_valid5, out_ready5;
  logic [39:0] ch_data5;
  logic [2:0]  sel_a5, sel_b5;
  logic [2:0]  op5;
  logic [7:0]  out_data5;
  logic        carry5, zero5, ovf5, err5;

  int n_checks = 0;
  int n_fail   = 0;

  mux_alu_pipe #(.WIDTH(8), .NUM_CH(4)) u_dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .ch_data(ch_data), .sel_a(sel_a), .sel_b(sel_b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .carry(carry), .zero(zero), .ovf(ovf), .err(err)
  );

  mux_alu_pipe #(.WIDTH(8), .NUM_CH(5)) u_dut5 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid5), .in_ready(in_ready5),
    .ch_data(ch_data5), .sel_a(sel_a5), .sel_b(sel_b5), .op(op5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
    .carry(carry5), .zero(zero5), .ovf(ovf5), .err(err5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the 4-channel instance with out_ready=1.
  // Checks latency (not valid after 1 clock, valid after 2) and the result.
  // Flags are compared as {carry, zero, ovf, err}.
  task automatic do_op(input string tag, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [2:0] o, input logic [7:0] exp_d, input logic [3:0] exp_f);
    sel_a    = sa;
    sel_b    = sb;
    op       = o;
    in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"}, 32'(out_data), 32'(exp_d));
    chk({tag, ".flags"}, 32'({carry, zero, ovf, err}), 32'(exp_f));
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ch_data   = '0;
    sel_a     = '0;
    sel_b     = '0;
    op        = OPC_ADD;
    in_valid5 = 1'b0;
    out_ready5 = 1'b1;
    ch_data5  = '0;
    sel_a5    = '0;
    sel_b5    = '0;
    op5       = OPC_ADD;

    step();
    step();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.flags", 32'({carry, zero, ovf, err}), 32'd0);
    rstn = 1'b1;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    step();

    // ch3=01 ch2=7F ch1=20 ch0=F0
    ch_data = 32'h01_7F_20_F0;
    do_op("add_carry", 2'd0, 2'd1, OPC_ADD, SAT ? 8'hFF : 8'h10, 4'b1000);
    do_op("add_ovf",   2'd2, 2'd3, OPC_ADD, 8'h80, 4'b0010);
    do_op("sub_zero",  2'd3, 2'd3, OPC_SUB, 8'h00, 4'b0100);
    do_op("and",       2'd0, 2'd1, OPC_AND, 8'h20, 4'b0000);
    do_op("or",        2'd0, 2'd1, OPC_OR,  8'hF0, 4'b0000);
    do_op("xor",       2'd0, 2'd1, OPC_XOR, 8'hD0, 4'b0000);
    do_op("pass",      2'd2, 2'd0, OPC_PASS, 8'h7F, 4'b0000);
    do_op("sub_borrow", 2'd1, 2'd0, OPC_SUB, SAT ? 8'h00 : 8'h30, SAT ? 4'b1100 : 4'b1000);
    do_op("shr1",      2'd0, 2'd3, OPC_SHR, 8'h78, 4'b0000);
    do_op("shr0",      2'd0, 2'd1, OPC_SHR, 8'hF0, 4'b0000);

    // Drain, then backpressure with three back-to-back offers.
    step();
    chk("drain.out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    sel_a = 2'd0; sel_b = 2'd1; op = OPC_AND; in_valid = 1'b1;
    step();
    op = OPC_OR;
    chk("bp.in_ready2", 32'(in_ready), 32'd1);
    step();
    op = OPC_XOR;
    chk("bp.in_ready3", 32'(in_ready), 32'd0);
    chk("bp.valid", 32'(out_valid), 32'd1);
    chk("bp.data0", 32'(out_data), 32'h20);
    step();
    chk("bp.hold_data", 32'(out_data), 32'h20);
    chk("bp.hold_ready", 32'(in_ready), 32'd0);
    step();
    chk("bp.hold_data2", 32'(out_data), 32'h20);
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp.data1", 32'(out_data), 32'hF0);
    chk("bp.valid1", 32'(out_valid), 32'd1);
    step();
    chk("bp.data2", 32'(out_data), 32'hD0);
    chk("bp.valid2", 32'(out_valid), 32'd1);
    step();
    chk("bp.empty", 32'(out_valid), 32'd0);

    ch_data = 32'h00_00_09_05;
    do_op("sub_05_09", 2'd0, 2'd1, OPC_SUB, SAT ? 8'h00 : 8'hFC, SAT ? 4'b1100 : 4'b1000);

    // ch3=07 ch2=08 ch1=01 ch0=81
    ch_data = 32'h07_08_01_81;
    do_op("shl1",  2'd0, 2'd1, OPC_SHL, 8'h02, 4'b1000);
    do_op("shl0",  2'd0, 2'd2, OPC_SHL, 8'h81, 4'b0000);
    do_op("shl7",  2'd0, 2'd3, OPC_SHL, 8'h80, 4'b0000);
    do_op("shr1b", 2'd0, 2'd1, OPC_SHR, 8'h40, 4'b1000);

    // Fill both stages, then reset mid-operation.
    out_ready = 1'b0;
    sel_a = 2'd0; sel_b = 2'd1; op = OPC_SHL; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk("full.valid", 32'(out_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.data", 32'(out_data), 32'd0);
    chk("midrst.flags", 32'({carry, zero, ovf, err}), 32'd0);
    #2;
    rstn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst.no_valid", 32'(out_valid), 32'd0);
    end

    // 5-channel instance: ch4=0C ch1=33, others 0.
    ch_data5 = 40'h0C_00_00_33_00;
    sel_a5 = 3'd6; sel_b5 = 3'd1; op5 = OPC_OR; in_valid5 = 1'b1;
    step();
    sel_a5 = 3'd4; sel_b5 = 3'd1; op5 = OPC_XOR;
    step();
    chk("n5.or_valid", 32'(out_valid5), 32'd1);
    chk("n5.or_data", 32'(out_data5), 32'h33);
    chk("n5.or_flags", 32'({carry5, zero5, ovf5, err5}), 32'b0001);
    sel_a5 = 3'd1; sel_b5 = 3'd5; op5 = OPC_AND;
    step();
    in_valid5 = 1'b0;
    chk("n5.xor_data", 32'(out_data5), 32'h3F);
    chk("n5.xor_flags", 32'({carry5, zero5, ovf5, err5}), 32'b0000);
    step();
    chk("n5.and_data", 32'(out_data5), 32'h00);
    chk("n5.and_flags", 32'({carry5, zero5, ovf5, err5}), 32'b0101);
    step();
    chk("n5.empty", 32'(out_valid5), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_alu_pipe.md
Name: mux_alu_pipe

Overview:
- Parametrised successor to the 4-input enable-gated mux: NUM_CH input channels of WIDTH bits.
- Two independent operand selects feed an 8-op ALU.
- Two-stage pipeline with valid/ready handshake on both sides and result flags.
- Sits between the channel register bank and the result sink in the layered-testbench DUT set.

Parameters:
WIDTH, 8, data width of each channel and of the result (>=4)
NUM_CH, 4, number of input channels (>=2; need not be a power of 2)
SEL_W, $clog2(NUM_CH), select width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  input transaction valid
in_ready  output  1  block can accept input this cycle
ch_data  input  NUM_CH*WIDTH  flattened channels, channel k at [k*WIDTH +: WIDTH]
sel_a  input  SEL_W  channel index for operand A
sel_b  input  SEL_W  channel index for operand B
op  input  3  opcode (op_e)
out_valid  output  1  result valid
out_ready  input  1  sink accepts result
out_data  output  WIDTH  result
carry  output  1  ADD carry-out / SUB borrow / last bit shifted out
zero  output  1  out_data == 0
ovf  output  1  signed overflow (ADD/SUB only, else 0)
err  output  1  sel_a or sel_b >= NUM_CH for this transaction

Behaviour:
- Reset: rstn low asynchronously clears s1_valid, s2_valid, out_data, carry, zero, ovf, err to 0. in_ready reads 1 once rstn is high.
- Reset mid-operation: both stages are flushed, in-flight transactions are lost, and no out_valid pulse follows.
- Handshake: a transfer occurs on an edge where valid && ready.
  - Inputs must be held stable while in_valid && !in_ready.
  - out_* are held stable while out_valid && !out_ready.
- Stage 1 (S1):
  - On accept, register operand A = ch_data[sel_a], operand B = ch_data[sel_b], op, and err = (sel_a>=NUM_CH)||(sel_b>=NUM_CH).
  - An out-of-range select yields an operand of 0.
- Stage 2 (S2):
  - Compute the ALU result from the S1 registers and register out_data and the flags. out_valid = s2_valid.
- Stall logic:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_load (combinational from registers and out_ready only; no path from in_valid).
- Latency: 2 clocks from input accept to out_valid with out_ready=1. Throughput: 1 per clock. Order is always preserved.
- Opcodes:
  - 000 ADD: {carry,res} = A+B.
  - 001 SUB: res = A-B, carry = (A<B).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 PASS_A.
  - 110 SHL by B[$clog2(WIDTH)-1:0]; carry = last bit shifted out, 0 if shift is 0.
  - 111 SHR (logical), same amount and carry rule.
- ovf:
  - ADD: A[msb]==B[msb] && res[msb]!=A[msb].
  - SUB: A[msb]!=B[msb] && res[msb]!=A[msb].
- Flags are registered together with out_data. zero reflects the final out_data, after any saturation.
- Simultaneous accept and output drain in the same cycle: both occur, with no bubble.

Optional Feature:
MUX_ALU_SAT_EN
- Defined: ADD clamps out_data to all-ones when carry=1; SUB clamps to 0 when borrow=1. carry and ovf still report the unsaturated event.
- Undefined: ADD/SUB wrap modulo 2^WIDTH. No saturation logic is present.

Decomposition:
- Package mux_alu_pkg holds:
  - op_e enum (3-bit, codes above).
  - alu_flags_t struct {carry, zero, ovf, err}.
  - Localparam opcode constants for the bench's reference model.
- Sub-module mux_alu_core:
  - Purely combinational ALU: A, B, op -> result plus carry/ovf.
  - Parametrised by WIDTH; contains the MUX_ALU_SAT_EN logic.
- The pipeline and handshake stay in mux_alu_pipe.

Test Plan (WIDTH=8, NUM_CH=4 unless noted):
- Reset release, then in_valid with ch0=0xF0, ch1=0x20, sel_a=0, sel_b=1, ADD, out_ready=1 -> out_valid 2 clocks later; out_data=0x10, carry=1, zero=0, ovf=0, err=0.
- ch2=0x7F, ch3=0x01, ADD -> 0x80, ovf=1, carry=0; then ch3 minus ch3 via SUB, sel_a=sel_b=3 -> 0x00, zero=1, carry=0.
- Backpressure: out_ready=0, offer 3 back-to-back transactions -> first two accepted, in_ready=0 on the third; out_data held stable; release out_ready -> results emerge in order, one per clock.
- NUM_CH=5 build: sel_a=6, ch1=0x33, sel_b=1, OR -> out_data=0x33, err=1.
- SHL ch0=0x81 by ch1=0x01 -> 0x02, carry=1. Assert rstn low while S1 and S2 are both valid -> outputs 0 immediately, no out_valid after release.
- MUX_ALU_SAT_EN defined: 0xF0+0x20 -> 0xFF, carry=1; 0x05-0x09 -> 0x00, carry=1, zero=1.
